multiplication_float_32: RTL and testbench



---
 rtl/float32_pkg.sv | 31 +++
 rtl/multiplication_float_32_if.sv | 15 +
 rtl/shift_add_mul_24.sv | 60 ++++++
 rtl/multiplication_float_32.sv | 158 +++++++++++++++
 tb/tb_multiplication_float_32.sv | 106 ++++++++++
 5 files changed

// File: rtl/float32_pkg.sv
// Shared float32 field layout, constants and FSM encoding for the ALU
// multiply/divide units.
package float32_pkg;

    localparam int unsigned MANT_BITS = 23;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned SIG_W     = MANT_BITS + 1;
    localparam int unsigned PROD_W    = 2 * SIG_W;
    localparam int unsigned STEP_W    = 5;
    localparam int unsigned EXPC_W    = 10;
    localparam int unsigned SIGN_POS  = 31;
    localparam int unsigned EXP_MSB   = 30;
    localparam int unsigned EXP_LSB   = 23;
    localparam int unsigned FRAC_MSB  = 22;
    localparam int unsigned EXP_BIAS  = 127;
    localparam int unsigned EXP_MAX   = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Hidden-bit significand; zero and denormal inputs flush to zero.
    function automatic logic [SIG_W-1:0] significand(input logic [31:0] x);
        if (x[EXP_MSB:EXP_LSB] == '0) return '0;
        return {1'b1, x[FRAC_MSB:0]};
    endfunction

endpackage

// File: rtl/multiplication_float_32_if.sv
// Start/finish handshake and operand/result bus shared by the ALU float units.
interface multiplication_float_32_if;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result;
    logic        finish;
    logic        busy;
    logic        overflow;

    modport master (output start, operand1, operand2,
                    input  result, finish, busy, overflow);
    modport slave  (input  start, operand1, operand2,
                    output result, finish, busy, overflow);
endinterface

// File: rtl/shift_add_mul_24.sv
// Iterative unsigned 24x24 -> 48 shift-and-add core, one partial product per clock.
module shift_add_mul_24
    import float32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SIG_W-1:0]  mcand,
    input  logic [SIG_W-1:0]  mplier,
    output logic [PROD_W-1:0] product,
    output logic              done_c
);

    logic [SIG_W-1:0]  mcand_q,  mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [PROD_W-1:0] acc_q,    acc_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic              active_q, active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        active_d = active_q;
        if (load) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = '0;
            step_d   = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (mplier_q[0]) acc_d = acc_q + (PROD_W'(mcand_q) << step_q);
            mplier_d = mplier_q >> 1;
            step_d   = step_q + STEP_W'(1);
            if (step_q == STEP_W'(SIG_W - 1)) active_d = 1'b0;
        end
    end

    // High during the final accumulation cycle so the owner can advance in step.
    assign done_c  = active_q && (step_q == STEP_W'(SIG_W - 1));
    assign product = acc_q;

endmodule

// File: rtl/multiplication_float_32.sv
// Multi-cycle float32 multiplier: shift-and-add significand core, then normalise,
// special-case and pack. Define ROUND_NEAREST_EN for round-to-nearest-even.
module multiplication_float_32
    import float32_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    multiplication_float_32_if.slave  bus
);

    logic [1:0]        state_q, state_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic [31:0]       result_q, result_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              core_load_c;
    logic              core_done_c;
    logic [PROD_W-1:0] prod;
    logic [31:0]       norm_result_c;
    logic              norm_ovf_c;

    shift_add_mul_24 u_core (
        .clk    (clock),
        .rst    (reset),
        .load   (core_load_c),
        .mcand  (significand(bus.operand1)),
        .mplier (significand(bus.operand2)),
        .product(prod),
        .done_c (core_done_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op1_q      <= '0;
            op2_q      <= '0;
            result_q   <= '0;
            finish_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            result_q   <= result_d;
            finish_q   <= finish_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        result_d    = result_q;
        finish_d    = finish_q;
        busy_d      = busy_q;
        overflow_d  = overflow_q;
        core_load_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    op1_d       = bus.operand1;
                    op2_d       = bus.operand2;
                    finish_d    = 1'b0;
                    overflow_d  = 1'b0;
                    busy_d      = 1'b1;
                    core_load_c = 1'b1;
                    state_d     = MUL;
                end
            end
            MUL: begin
                if (core_done_c) state_d = NORM;
            end
            NORM: begin
                result_d   = norm_result_c;
                overflow_d = norm_ovf_c;
                finish_d   = 1'b1;
                busy_d     = 1'b0;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic                    sign_c;
    logic [EXP_W-1:0]        e1_c, e2_c;
    logic                    nan_c, inf_c, zero_c, inf_zero_c;
    logic signed [EXPC_W-1:0] exp_c;
    logic [MANT_BITS-1:0]    frac_c;
    logic                    unused_low;

    // Normalise the 48-bit product, then apply special cases in priority order.
    always_comb begin
        sign_c     = op1_q[SIGN_POS] ^ op2_q[SIGN_POS];
        e1_c       = op1_q[EXP_MSB:EXP_LSB];
        e2_c       = op2_q[EXP_MSB:EXP_LSB];
        nan_c      = (e1_c == 8'hFF && op1_q[FRAC_MSB:0] != '0) ||
                     (e2_c == 8'hFF && op2_q[FRAC_MSB:0] != '0);
        inf_c      = (e1_c == 8'hFF) || (e2_c == 8'hFF);
        zero_c     = (e1_c == '0) || (e2_c == '0);
        inf_zero_c = inf_c && zero_c;
        exp_c      = $signed(EXPC_W'(e1_c)) + $signed(EXPC_W'(e2_c))
                     - $signed(EXPC_W'(EXP_BIAS));
`ifdef ROUND_NEAREST_EN
        begin
            logic              guard, sticky;
            logic [MANT_BITS:0] rnd;
            if (prod[PROD_W-1]) begin
                frac_c = prod[46:24];
                guard  = prod[23];
                sticky = |prod[22:0];
                exp_c  = exp_c + EXPC_W'(1);
            end else begin
                frac_c = prod[45:23];
                guard  = prod[22];
                sticky = |prod[21:0];
            end
            rnd = {1'b0, frac_c} + (MANT_BITS + 1)'(guard & (sticky | frac_c[0]));
            frac_c = rnd[MANT_BITS-1:0];
            if (rnd[MANT_BITS]) exp_c = exp_c + EXPC_W'(1);
        end
        unused_low = 1'b0;
`else
        if (prod[PROD_W-1]) begin
            frac_c = prod[46:24];
            exp_c  = exp_c + EXPC_W'(1);
        end else begin
            frac_c = prod[45:23];
        end
        unused_low = ^prod[22:0];
`endif
        norm_ovf_c = 1'b0;
        if (nan_c || inf_zero_c) begin
            norm_result_c = QNAN;
        end else if (inf_c) begin
            norm_result_c = {sign_c, 8'hFF, 23'd0};
        end else if (zero_c) begin
            norm_result_c = {sign_c, 31'd0};
        end else if (exp_c >= $signed(EXPC_W'(EXP_MAX))) begin
            norm_result_c = {sign_c, 8'hFF, 23'd0};
            norm_ovf_c    = 1'b1;
        end else if (exp_c <= $signed(EXPC_W'(0))) begin
            norm_result_c = {sign_c, 31'd0};
        end else begin
            norm_result_c = {sign_c, exp_c[EXP_W-1:0], frac_c};
        end
    end

    assign bus.result   = result_q;
    assign bus.finish   = finish_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_multiplication_float_32.sv
// Directed-vector bench for the float32 multiplier: latency, handshake,
// normalisation, special cases and reset abort.
module tb_multiplication_float_32;

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    multiplication_float_32_if bus();

    multiplication_float_32 dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one multiply, scramble operands after acceptance, and check latency and outputs.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_o,
                          input logic hold_start, input string tag);
        int edges;
        @(negedge clock);
        bus.start = 1'b1; bus.operand1 = a; bus.operand2 = b;
        @(posedge clock); #1;
        edges = 1;
        if (!hold_start) bus.start = 1'b0;
        bus.operand1 = $urandom; bus.operand2 = $urandom;
        check({tag, " busy@1"}, 32'(bus.busy), 32'd1);
        check({tag, " finish@1"}, 32'(bus.finish), 32'd0);
        while (!bus.finish && edges < 40) begin
            @(posedge clock); #1;
            edges++;
            if (edges == 25) check({tag, " busy@25"}, 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'd26);
        check({tag, " result"}, bus.result, exp_r);
        check({tag, " overflow"}, 32'(bus.overflow), 32'(exp_o));
        check({tag, " busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.operand1 = '0; bus.operand2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", bus.result, 32'h0);
        check("reset finish", 32'(bus.finish), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b0;

        mul_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, "2x3");
        mul_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, "1.5sq");
        mul_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b0, 1'b1, "-2x0.5 held");
        mul_op(32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0, 1'b0, "-0x3");
        mul_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, "inf x 0");
        mul_op(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, "nan x 1");
        mul_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, "-inf x 2");
        mul_op(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, "denorm x 1");
        mul_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, "ovf");
        mul_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b0, "underflow");
`ifdef ROUND_NEAREST_EN
        mul_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 1'b0, 1'b0, "round");
`else
        mul_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, 1'b0, 1'b0, "trunc");
`endif

        // Reset on edge 10 aborts the multiply with no finish pulse.
        @(negedge clock);
        bus.start = 1'b1; bus.operand1 = 32'h4000_0000; bus.operand2 = 32'h4040_0000;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int e = 2; e <= 9; e++) begin
            @(posedge clock); #1;
            if (e == 9) check("abort finish@9", 32'(bus.finish), 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort finish", 32'(bus.finish), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort result", bus.result, 32'h0);
        repeat (20) begin
            @(posedge clock); #1;
        end
        check("abort no late finish", 32'(bus.finish), 32'd0);
        mul_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, "restart 2x3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
